control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle instruction sequencer for the ToastCPU core. It sits directly upstream of `datapath` and drives every one of its control inputs. It consumes `current_instruction`, the Z/N status flags and the memory read-valid strobe. It steps each instruction through fetch, execute and optional memory or stack phases, and supports free-run, single-step and halt.

## Interface
Parameters:
- `START_RUNNING`, default 1: value `run` is treated as having while `reset` is low.

Ports:
- `clock` in 1: system clock; all state changes on rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `run` in 1: level; 1 = free-run, 0 = single-step mode.
- `step` in 1: one-cycle pulse; permits one instruction in single-step mode.
- `current_instruction` in 16: latched instruction from the datapath.
- `Z_in`, `N_in` in 1 each: status flags SR[1], SR[2].
- `mem_rvalid` in 1: memory read data valid for the address held since the previous cycle.
- `reg_write`, `mem_to_reg`, `fetch_instruction`, `alu_override_imm8`, `alu_override_imm4`, `alu_set_flags`, `set_pc`, `pc_from_register`, `mem_write`, `mem_write_is_stack`, `mem_write_next_pc`, `set_sp`, `increase_sp` out 1 each: datapath controls, Moore-decoded from state plus opcode.
- `halted` out 1: core stopped.
- `illegal` out 1: halt was caused by an undefined opcode.
- `state_poke` out 4: current state encoding, for debug display.

## Operation
- Instruction fields:
  - opcode [15:12]
  - r1 [11:8]
  - r2 [7:4]
  - alu_op / cond [3:0]
- Opcodes:
  - 0 NOP
  - 1 ALU r1 ← r1 op r2
  - 2 ALUI r1 ← r1 op imm4
  - 3 LDI r1 ← sext(imm8)
  - 4 LOAD r1 ← mem[r2]
  - 5 STORE mem[r1] ← r2
  - 6 JMP
  - 7 HALT
  - 8 CALL
  - 9–15 illegal
- JMP cond field:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 N
  - 4 !N
  - any other value is never taken; it acts as a NOP.
- States: FETCH_ADDR, FETCH_WAIT, EXEC, LOAD_ADDR, LOAD_WAIT, CALL_JUMP, HALT.
- FETCH_ADDR:
  - `fetch_instruction`=1.
  - Advances to FETCH_WAIT if `run`=1 or `step_pending`=1, clearing `step_pending`. Otherwise it holds.
- FETCH_WAIT:
  - `fetch_instruction`=1.
  - When `mem_rvalid`=1 the datapath latches the instruction and the FSM goes to EXEC.
- EXEC: PC is not incremented during fetch. It advances here, using `set_pc`=1 and `pc_from_register`=0, unless a jump is taken. Per opcode:
  - NOP: PC advances.
  - ALU: `reg_write`=1, `alu_set_flags`=1, PC advances.
  - ALUI: same as ALU, plus `alu_override_imm4`=1.
  - LDI: `alu_override_imm8`=1, `reg_write`=1, PC advances.
  - STORE: `mem_write`=1, PC advances.
  - JMP taken: `set_pc`=1, `pc_from_register`=1.
  - JMP not taken: PC advances.
  - LOAD: no strobes; next state LOAD_ADDR.
  - CALL: `mem_write`=1, `mem_write_is_stack`=1, `mem_write_next_pc`=1, `set_sp`=1, `increase_sp`=0. This pushes PC+1 at SP and decrements SP. Next state CALL_JUMP.
  - HALT or illegal opcode: next state HALT; `illegal` is set only for an illegal opcode.
  - All other opcodes return to FETCH_ADDR.
- LOAD_ADDR: `mem_to_reg`=1; address is r2. Always goes to LOAD_WAIT.
- LOAD_WAIT:
  - `mem_to_reg`=1.
  - On `mem_rvalid`=1: `reg_write`=1, `set_pc`=1, next state FETCH_ADDR.
- CALL_JUMP: `set_pc`=1, `pc_from_register`=1, next state FETCH_ADDR.
- HALT:
  - All controls are 0 and `halted`=1.
  - Only reset leaves this state; `run` and `step` are ignored.
- Step capture:
  - `step_pending` is set by `step`=1 in any state except HALT.
  - It is cleared when consumed in FETCH_ADDR.
  - Multiple pulses before consumption count as one.
  - If a pulse arrives in the same cycle as consumption, it stays pending.

## Timing
- Reset values:
  - state FETCH_ADDR
  - `step_pending`=0
  - `halted`=0
  - `illegal`=0
  - all control outputs 0, except `fetch_instruction`=1, which is decoded from FETCH_ADDR.
- Reset asserted mid-instruction returns to FETCH_ADDR immediately. No partial strobe is emitted after reset is released.
- Minimum cycles per instruction, with `mem_rvalid` returned one cycle after the address:
  - NOP, ALU, ALUI, LDI, STORE, JMP: 3
  - CALL: 4
  - LOAD: 5
- Each write strobe is asserted for exactly one cycle per instruction.
- `mem_rvalid` is ignored in FETCH_ADDR and LOAD_ADDR. A stale valid from the previous address must not be used.
- Flags sampled by JMP are the SR value at the start of EXEC. This includes an update made by an immediately preceding ALU instruction.

## Structure
- Shared package `toast_pkg` holds:
  - `opcode_t` enum (4 b)
  - `jcond_t` enum (4 b)
  - `cpu_state_t` enum (4 b, matching the `state_poke` encoding)
  - `SP_RESET` = 16'h8000
- The state register and output decode live in one module. No sub-module is needed.
- The top level must wire `mem_rvalid` out of `datapath` to this block.

## Test plan
- Reset, then `run`=1, with program `3105` (LDI r1,5), `2120` (ALUI r1 += 2, alu_op 0 = ADD), `7000` → r1=0x0007. The core halts after 9 cycles with `halted`=1 and `illegal`=0.
- LDI r2,0x40; STORE r2←r3; LOAD r4←[r2] → r4 equals r3. LOAD takes 5 cycles. `mem_to_reg` is high in both LOAD_ADDR and LOAD_WAIT.
- With Z=1: JMP r5, cond 1, where r5=0x0010 → PC=0x0010. With Z=0: same instruction gives PC = old PC+1.
- CALL r5 with SP=0x8000 and PC=0x0003 → mem[0x8000]=0x0004, SP=0x7FFF, PC=r5.
- `run`=0 with three `step` pulses, two of them in the same cycle window → exactly two instructions execute and the FSM holds in FETCH_ADDR.
- Opcode 0xA000 → HALT with `illegal`=1. Reset asserted mid-LOAD_WAIT → state FETCH_ADDR and no `reg_write`.

Source files
------------

// File: rtl/toast_pkg.sv
// toast_pkg: shared ToastCPU types (opcodes, jump conditions, sequencer states).
// Also holds the stack pointer reset value and the jump condition helper.
package toast_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ALU   = 4'd1,
        OP_ALUI  = 4'd2,
        OP_LDI   = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_JMP   = 4'd6,
        OP_HALT  = 4'd7,
        OP_CALL  = 4'd8
    } opcode_t;

    typedef enum logic [3:0] {
        JC_ALWAYS = 4'd0,
        JC_Z      = 4'd1,
        JC_NZ     = 4'd2,
        JC_N      = 4'd3,
        JC_NN     = 4'd4
    } jcond_t;

    typedef enum logic [3:0] {
        FETCH_ADDR = 4'd0,
        FETCH_WAIT = 4'd1,
        EXEC       = 4'd2,
        LOAD_ADDR  = 4'd3,
        LOAD_WAIT  = 4'd4,
        CALL_JUMP  = 4'd5,
        HALT       = 4'd6
    } cpu_state_t;

    localparam logic [15:0] SP_RESET = 16'h8000;

    // Undefined condition codes never jump, so JMP degrades to a NOP.
    function automatic logic jmp_taken(
        input logic [3:0] cond,
        input logic       z,
        input logic       n
    );
        logic t;
        t = 1'b0;
        case (cond)
            JC_ALWAYS: t = 1'b1;
            JC_Z:      t = z;
            JC_NZ:     t = ~z;
            JC_N:      t = n;
            JC_NN:     t = ~n;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer driving the ToastCPU datapath.
// Inputs: clock, reset (async, active-low), run, step, current_instruction,
// Z_in/N_in flags, mem_rvalid. Outputs: datapath strobes decoded from state
// and opcode, plus halted, illegal and state_poke for debug display.
module control_fsm
    import toast_pkg::*;
#(
    parameter bit START_RUNNING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [15:0] current_instruction,
    input  logic        Z_in,
    input  logic        N_in,
    input  logic        mem_rvalid,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        fetch_instruction,
    output logic        alu_override_imm8,
    output logic        alu_override_imm4,
    output logic        alu_set_flags,
    output logic        set_pc,
    output logic        pc_from_register,
    output logic        mem_write,
    output logic        mem_write_is_stack,
    output logic        mem_write_next_pc,
    output logic        set_sp,
    output logic        increase_sp,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_poke
);

    cpu_state_t  state_q, state_d;
    logic        step_pending_q, step_pending_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        run_eff;
    logic        taken;
    logic        unused_fields;

    assign opcode = current_instruction[15:12];
    assign cond   = current_instruction[3:0];
    // Register fields are consumed by the datapath, not the sequencer.
    assign unused_fields = ^current_instruction[11:4];

    assign run_eff = reset ? run : START_RUNNING;
    assign taken   = jmp_taken(cond, Z_in, N_in);

    // Next state, step capture and sticky illegal flag.
    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        illegal_d      = illegal_q;
        unique case (state_q)
            FETCH_ADDR: begin
                if (run_eff || step_pending_q) begin
                    state_d        = FETCH_WAIT;
                    step_pending_d = 1'b0;
                end
            end
            FETCH_WAIT: begin
                if (mem_rvalid) state_d = EXEC;
            end
            EXEC: begin
                case (opcode)
                    OP_NOP, OP_ALU, OP_ALUI, OP_LDI,
                    OP_STORE, OP_JMP: state_d = FETCH_ADDR;
                    OP_LOAD: state_d = LOAD_ADDR;
                    OP_CALL: state_d = CALL_JUMP;
                    OP_HALT: state_d = HALT;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            LOAD_ADDR: state_d = LOAD_WAIT;
            LOAD_WAIT: begin
                if (mem_rvalid) state_d = FETCH_ADDR;
            end
            CALL_JUMP: state_d = FETCH_ADDR;
            HALT:      state_d = HALT;
            default:   state_d = FETCH_ADDR;
        endcase
        // A pulse coinciding with consumption stays pending.
        if (step && (state_q != HALT)) step_pending_d = 1'b1;
    end

    assign halted_d = (state_d == HALT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= FETCH_ADDR;
            step_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            halted_q       <= halted_d;
            illegal_q      <= illegal_d;
        end
    end

    // Datapath strobes decoded from the current state and latched opcode.
    always_comb begin
        reg_write          = 1'b0;
        mem_to_reg         = 1'b0;
        fetch_instruction  = 1'b0;
        alu_override_imm8  = 1'b0;
        alu_override_imm4  = 1'b0;
        alu_set_flags      = 1'b0;
        set_pc             = 1'b0;
        pc_from_register   = 1'b0;
        mem_write          = 1'b0;
        mem_write_is_stack = 1'b0;
        mem_write_next_pc  = 1'b0;
        set_sp             = 1'b0;
        increase_sp        = 1'b0;
        unique case (state_q)
            FETCH_ADDR, FETCH_WAIT: fetch_instruction = 1'b1;
            EXEC: begin
                case (opcode)
                    OP_NOP: set_pc = 1'b1;
                    OP_ALU: begin
                        reg_write     = 1'b1;
                        alu_set_flags = 1'b1;
                        set_pc        = 1'b1;
                    end
                    OP_ALUI: begin
                        reg_write         = 1'b1;
                        alu_set_flags     = 1'b1;
                        alu_override_imm4 = 1'b1;
                        set_pc            = 1'b1;
                    end
                    OP_LDI: begin
                        reg_write         = 1'b1;
                        alu_override_imm8 = 1'b1;
                        set_pc            = 1'b1;
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        set_pc    = 1'b1;
                    end
                    OP_JMP: begin
                        set_pc           = 1'b1;
                        pc_from_register = taken;
                    end
                    // Push PC+1 at SP, then SP decrements.
                    OP_CALL: begin
                        mem_write          = 1'b1;
                        mem_write_is_stack = 1'b1;
                        mem_write_next_pc  = 1'b1;
                        set_sp             = 1'b1;
                    end
                    default: ;
                endcase
            end
            LOAD_ADDR: mem_to_reg = 1'b1;
            LOAD_WAIT: begin
                mem_to_reg = 1'b1;
                reg_write  = mem_rvalid;
                set_pc     = mem_rvalid;
            end
            CALL_JUMP: begin
                set_pc           = 1'b1;
                pc_from_register = 1'b1;
            end
            HALT:    ;
            default: ;
        endcase
    end

    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign state_poke = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed and randomized checks of the ToastCPU sequencer
// against an instruction-level model of its effects.
module tb_control_fsm;
    import toast_pkg::*;

    logic        clock;
    logic        reset;
    logic        run;
    logic        step;
    logic [15:0] current_instruction;
    logic        Z_in;
    logic        N_in;
    logic        mem_rvalid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        fetch_instruction;
    logic        alu_override_imm8;
    logic        alu_override_imm4;
    logic        alu_set_flags;
    logic        set_pc;
    logic        pc_from_register;
    logic        mem_write;
    logic        mem_write_is_stack;
    logic        mem_write_next_pc;
    logic        set_sp;
    logic        increase_sp;
    logic        halted;
    logic        illegal;
    logic [3:0]  state_poke;

    int total;
    int bad;

    int n_rw, n_flags, n_i4, n_i8, n_mw, n_stk, n_npc;
    int n_ssp, n_isp, n_fetch, n_m2r, n_setpc, n_pcreg, n_halt;
    logic [15:0] pc_obs, sp_obs, tgt_cur, pushed;

    control_fsm #(.START_RUNNING(1'b1)) dut (
        .clock(clock),
        .reset(reset),
        .run(run),
        .step(step),
        .current_instruction(current_instruction),
        .Z_in(Z_in),
        .N_in(N_in),
        .mem_rvalid(mem_rvalid),
        .reg_write(reg_write),
        .mem_to_reg(mem_to_reg),
        .fetch_instruction(fetch_instruction),
        .alu_override_imm8(alu_override_imm8),
        .alu_override_imm4(alu_override_imm4),
        .alu_set_flags(alu_set_flags),
        .set_pc(set_pc),
        .pc_from_register(pc_from_register),
        .mem_write(mem_write),
        .mem_write_is_stack(mem_write_is_stack),
        .mem_write_next_pc(mem_write_next_pc),
        .set_sp(set_sp),
        .increase_sp(increase_sp),
        .halted(halted),
        .illegal(illegal),
        .state_poke(state_poke)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ctrl_any();
        return reg_write | mem_to_reg | fetch_instruction |
               alu_override_imm8 | alu_override_imm4 | alu_set_flags |
               set_pc | pc_from_register | mem_write | mem_write_is_stack |
               mem_write_next_pc | set_sp | increase_sp;
    endfunction

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic rv, input logic st);
        @(negedge clock);
        mem_rvalid = rv;
        step       = st;
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_counts();
        n_rw = 0; n_flags = 0; n_i4 = 0; n_i8 = 0; n_mw = 0;
        n_stk = 0; n_npc = 0; n_ssp = 0; n_isp = 0; n_fetch = 0;
        n_m2r = 0; n_setpc = 0; n_pcreg = 0; n_halt = 0;
        pushed = 16'hxxxx;
    endtask

    // Tally strobes for the current cycle and apply them to PC/SP models.
    task automatic acc();
        if (reg_write) n_rw++;
        if (alu_set_flags) n_flags++;
        if (alu_override_imm4) n_i4++;
        if (alu_override_imm8) n_i8++;
        if (mem_write) n_mw++;
        if (mem_write_is_stack) n_stk++;
        if (mem_write_next_pc) begin
            n_npc++;
            pushed = pc_obs + 16'd1;
        end
        if (set_sp) n_ssp++;
        if (increase_sp) n_isp++;
        if (fetch_instruction) n_fetch++;
        if (mem_to_reg) n_m2r++;
        if (halted) n_halt++;
        if (set_pc) begin
            n_setpc++;
            if (pc_from_register) n_pcreg++;
            pc_obs = pc_from_register ? tgt_cur : pc_obs + 16'd1;
        end
        if (set_sp) sp_obs = increase_sp ? sp_obs + 16'd1 : sp_obs - 16'd1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        step       = 1'b0;
        #1;
        chk("rst_state", 32'(state_poke), 32'(FETCH_ADDR));
        chk("rst_fetch", 32'(fetch_instruction), 32'd1);
        chk("rst_rw", 32'(reg_write), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        pc_obs = 16'h0000;
        sp_obs = SP_RESET;
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic z,
                             input logic n, input logic [15:0] tgt,
                             input bit fast);
        logic [3:0]  op;
        logic [3:0]  c;
        int          fw;
        int          lw;
        logic        taken;
        logic        halts;
        logic [15:0] pc0;
        logic [15:0] sp0;
        logic [15:0] pc_exp;
        op = ins[15:12];
        c  = ins[3:0];
        fw = fast ? 0 : int'($urandom_range(0, 2));
        lw = fast ? 0 : int'($urandom_range(0, 2));
        clear_counts();
        tgt_cur = tgt;
        Z_in    = z;
        N_in    = n;
        pc0     = pc_obs;
        sp0     = sp_obs;
        cyc(rbit(), 1'b0); acc();
        repeat (fw) begin cyc(1'b0, 1'b0); acc(); end
        cyc(1'b1, 1'b0); acc();
        current_instruction = ins;
        cyc(rbit(), 1'b0); acc();
        if (op == 4'd4) begin
            cyc(rbit(), 1'b0); acc();
            repeat (lw) begin cyc(1'b0, 1'b0); acc(); end
            cyc(1'b1, 1'b0); acc();
        end
        if (op == 4'd8) begin
            cyc(rbit(), 1'b0); acc();
        end
        taken = (op == 4'd6) &&
                ((c == 4'd0) || (c == 4'd1 && z) || (c == 4'd2 && !z) ||
                 (c == 4'd3 && n) || (c == 4'd4 && !n));
        halts = (op == 4'd7) || (op > 4'd8);
        if (halts) pc_exp = pc0;
        else if (taken || op == 4'd8) pc_exp = tgt;
        else pc_exp = pc0 + 16'd1;
        chk("fetch_cycles", 32'(n_fetch), 32'(fw + 2));
        chk("mem_to_reg_cycles", 32'(n_m2r), (op == 4'd4) ? 32'(lw + 2) : 32'd0);
        chk("reg_write", 32'(n_rw), (op >= 4'd1 && op <= 4'd4) ? 32'd1 : 32'd0);
        chk("set_flags", 32'(n_flags), (op == 4'd1 || op == 4'd2) ? 32'd1 : 32'd0);
        chk("imm4", 32'(n_i4), (op == 4'd2) ? 32'd1 : 32'd0);
        chk("imm8", 32'(n_i8), (op == 4'd3) ? 32'd1 : 32'd0);
        chk("mem_write", 32'(n_mw), (op == 4'd5 || op == 4'd8) ? 32'd1 : 32'd0);
        chk("stack_push", 32'(n_stk + n_npc + n_ssp),
            (op == 4'd8) ? 32'd3 : 32'd0);
        chk("increase_sp", 32'(n_isp), 32'd0);
        chk("set_pc", 32'(n_setpc), halts ? 32'd0 : 32'd1);
        chk("pc_from_reg", 32'(n_pcreg), (taken || op == 4'd8) ? 32'd1 : 32'd0);
        chk("pc", 32'(pc_obs), 32'(pc_exp));
        chk("sp", 32'(sp_obs), (op == 4'd8) ? 32'(sp0 - 16'd1) : 32'(sp0));
        chk("halted_early", 32'(n_halt), 32'd0);
        if (op == 4'd8) chk("pushed", 32'(pushed), 32'(pc0 + 16'd1));
        if (halts) begin
            repeat (3) begin
                run = rbit();
                cyc(rbit(), rbit());
                chk("halt_halted", 32'(halted), 32'd1);
                chk("halt_illegal", 32'(illegal), (op > 4'd8) ? 32'd1 : 32'd0);
                chk("halt_state", 32'(state_poke), 32'(HALT));
                chk("halt_ctrl", 32'(ctrl_any()), 32'd0);
            end
            run = 1'b1;
            do_reset();
        end
    endtask

    initial begin
        int pcs;
        logic [3:0]  rop;
        logic [15:0] rins;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        run   = 1'b1;
        step  = 1'b0;
        mem_rvalid = 1'b0;
        Z_in  = 1'b0;
        N_in  = 1'b0;
        current_instruction = 16'h0000;
        pc_obs  = 16'h0000;
        sp_obs  = SP_RESET;
        tgt_cur = 16'h0000;
        clear_counts();
        do_reset();

        // LDI r1,5 ; ALUI r1+=2 ; HALT at minimum latency.
        run_instr(16'h3105, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_instr(16'h2120, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_instr(16'h7000, 1'b0, 1'b0, 16'h0000, 1'b1);

        // LDI r2 ; STORE ; LOAD with a 5-cycle LOAD.
        run_instr(16'h3240, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_instr(16'h5230, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_instr(16'h4420, 1'b0, 1'b0, 16'h0000, 1'b1);

        // JMP r5 cond Z, taken then not taken.
        run_instr(16'h6501, 1'b1, 1'b0, 16'h0010, 1'b1);
        run_instr(16'h6501, 1'b0, 1'b0, 16'h0010, 1'b1);

        // CALL from PC=3 with SP at reset value.
        do_reset();
        repeat (3) run_instr(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_instr(16'h8500, 1'b0, 1'b0, 16'h0123, 1'b1);

        // Illegal opcode.
        run_instr(16'hA000, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Reset during LOAD_WAIT with data arriving.
        current_instruction = 16'h4120;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("la_no_write", 32'(reg_write), 32'd0);
        cyc(1'b0, 1'b0);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        do_reset();
        chk("post_rst_state", 32'(state_poke), 32'(FETCH_ADDR));

        // Single-step: three pulses, two coalesced, yield two instructions.
        run = 1'b0;
        do_reset();
        current_instruction = 16'h0000;
        pcs = 0;
        repeat (3) begin
            cyc(1'b1, 1'b0);
            chk("step_hold", 32'(state_poke), 32'(FETCH_ADDR));
        end
        cyc(1'b1, 1'b1);
        chk("step_arm", 32'(state_poke), 32'(FETCH_ADDR));
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("step_fw", 32'(fetch_instruction), 32'd1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        repeat (20) begin
            cyc(1'b1, 1'b0);
            if (set_pc) pcs++;
        end
        chk("step_count", 32'(pcs), 32'd2);
        chk("step_idle", 32'(state_poke), 32'(FETCH_ADDR));
        run = 1'b1;
        do_reset();

        // Randomized instruction stream.
        repeat (80) begin
            if ($urandom_range(0, 19) < 18)
                rop = 4'($urandom_range(0, 8));
            else
                rop = 4'($urandom_range(9, 15));
            if (rop == 4'd7 && $urandom_range(0, 1) == 0) rop = 4'd0;
            rins = {rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 7))};
            run_instr(rins, rbit(), rbit(), 16'($urandom_range(0, 65535)),
                      1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
